// File: rtl/nn_ip_pkg.sv
// Shared widths and transmit-state encoding for the NN <-> UDP/IP buffer blocks.
package nn_ip_pkg;

  localparam int unsigned IP_ADDR_WIDTH   = 32;
  localparam int unsigned MAC_ADDR_WIDTH  = 48;
  localparam int unsigned UDP_PORT_WIDTH  = 16;
  localparam int unsigned SCORE_WIDTH_DEF = 18;
  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned IDX_WIDTH       = 8;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over a stream of signed scores; max_idx already reflects the beat being presented.
module argmax_tracker
  import nn_ip_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic [IDX_WIDTH-1:0]   index,
  output logic [IDX_WIDTH-1:0]   max_idx
);

  logic signed [SCORE_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]          idx_q;
  logic                          take_c;

  // Strictly greater replaces, so ties keep the earlier (lower) index.
  assign take_c  = valid && (clear || ($signed(score) > max_q));
  assign max_idx = take_c ? index : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (take_c) begin
      max_q <= $signed(score);
      idx_q <= index;
    end
  end

endmodule

// File: rtl/buff_nn_to_ip.sv
// Packs N_OUTPUTS NN scores into a UDP payload and holds it for the IP stack until acknowledged.
// Optional argmax byte appended when BUFF_NN_ARGMAX_EN is defined.
module buff_nn_to_ip
  import nn_ip_pkg::*;
#(
  parameter int unsigned N_OUTPUTS   = 10,
  parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEF,
`ifdef BUFF_NN_ARGMAX_EN
  localparam int unsigned FRAME_BYTES = 4 * N_OUTPUTS + 1
`else
  localparam int unsigned FRAME_BYTES = 4 * N_OUTPUTS
`endif
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [IP_ADDR_WIDTH-1:0]   SRC_IP_ADDRESS_NN,
  input  logic [MAC_ADDR_WIDTH-1:0]  SRC_MAC_ADDRESS_NN,
  input  logic [UDP_PORT_WIDTH-1:0]  SRC_UDP_PORT_NN,
  input  logic [SCORE_WIDTH-1:0]     R_DATA,
  input  logic                       R_VALID,
  output logic                       R_READY,
  output logic [FRAME_BYTES*8-1:0]   DATA_FRAME_IP,
  output logic [IP_ADDR_WIDTH-1:0]   DST_IP_ADDRESS_IP,
  output logic [MAC_ADDR_WIDTH-1:0]  DST_MAC_ADDRESS_IP,
  output logic [UDP_PORT_WIDTH-1:0]  DST_UDP_PORT_IP,
  output logic                       FRAME_VALID,
  input  logic                       FRAME_ACK
);

  localparam int unsigned FRAME_BITS = FRAME_BYTES * 8;
  localparam int unsigned CNT_W      = IDX_WIDTH;

  tx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          count_q;
  logic [FRAME_BITS-1:0]     frame_q;
  logic [IP_ADDR_WIDTH-1:0]  ip_q;
  logic [MAC_ADDR_WIDTH-1:0] mac_q;
  logic [UDP_PORT_WIDTH-1:0] port_q;
  logic                      ready_q;
  logic                      valid_q;
  logic                      accept_c;
  logic                      last_c;
  logic                      ack_c;
  logic [WORD_WIDTH-1:0]     word_c;

  assign word_c = WORD_WIDTH'($signed(R_DATA));

`ifdef BUFF_NN_ARGMAX_EN
  logic [IDX_WIDTH-1:0] max_idx;

  argmax_tracker #(
    .SCORE_WIDTH(SCORE_WIDTH)
  ) u_argmax (
    .clk    (ACLK),
    .rst_n  (ARESET),
    .clear  (count_q == '0),
    .valid  (accept_c),
    .score  (R_DATA),
    .index  (count_q),
    .max_idx(max_idx)
  );
`endif

  // Next state and per-cycle handshake qualifiers.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    ack_c    = 1'b0;
    case (state_q)
      FILL: begin
        accept_c = R_VALID && ready_q;
        last_c   = accept_c && (count_q == CNT_W'(N_OUTPUTS - 1));
        if (last_c) state_d = SEND;
      end
      SEND: begin
        ack_c = FRAME_ACK && valid_q;
        if (ack_c) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q <= FILL;
      count_q <= '0;
      frame_q <= '0;
      ip_q    <= '0;
      mac_q   <= '0;
      port_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == FILL);
      valid_q <= (state_d == SEND);
      // Score k lands big-endian in bytes 4k..4k+3; stale bytes are simply overwritten.
      for (int k = 0; k < int'(N_OUTPUTS); k++) begin
        if (accept_c && (count_q == CNT_W'(k)))
          frame_q[FRAME_BITS-1-WORD_WIDTH*k -: WORD_WIDTH] <= word_c;
      end
      if (accept_c && !last_c) count_q <= count_q + CNT_W'(1);
      if (ack_c) count_q <= '0;
      if (last_c) begin
        ip_q   <= SRC_IP_ADDRESS_NN;
        mac_q  <= SRC_MAC_ADDRESS_NN;
        port_q <= SRC_UDP_PORT_NN;
`ifdef BUFF_NN_ARGMAX_EN
        frame_q[7:0] <= max_idx;
`endif
      end
    end
  end

  assign R_READY            = ready_q;
  assign FRAME_VALID        = valid_q;
  assign DATA_FRAME_IP      = frame_q;
  assign DST_IP_ADDRESS_IP  = ip_q;
  assign DST_MAC_ADDRESS_IP = mac_q;
  assign DST_UDP_PORT_IP    = port_q;

endmodule

// File: tb/tb_buff_nn_to_ip.sv
// Self-checking bench for buff_nn_to_ip: vector table, directed corner sequences and random frames.
module tb_buff_nn_to_ip;

  localparam int N  = 10;
  localparam int SW = 18;
`ifdef BUFF_NN_ARGMAX_EN
  localparam int FB = 4 * N + 1;
`else
  localparam int FB = 4 * N;
`endif
  localparam int FBITS = FB * 8;

  typedef logic [SW-1:0] score_t;
  typedef struct {
    score_t      score;
    logic [31:0] word;
  } vec_t;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [31:0]      src_ip;
  logic [47:0]      src_mac;
  logic [15:0]      src_port;
  score_t           R_DATA;
  logic             R_VALID;
  logic             R_READY;
  logic [FBITS-1:0] DATA_FRAME_IP;
  logic [31:0]      DST_IP_ADDRESS_IP;
  logic [47:0]      DST_MAC_ADDRESS_IP;
  logic [15:0]      DST_UDP_PORT_IP;
  logic             FRAME_VALID;
  logic             FRAME_ACK;

  buff_nn_to_ip #(.N_OUTPUTS(N), .SCORE_WIDTH(SW)) dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .SRC_IP_ADDRESS_NN (src_ip),
    .SRC_MAC_ADDRESS_NN(src_mac),
    .SRC_UDP_PORT_NN   (src_port),
    .R_DATA            (R_DATA),
    .R_VALID           (R_VALID),
    .R_READY           (R_READY),
    .DATA_FRAME_IP     (DATA_FRAME_IP),
    .DST_IP_ADDRESS_IP (DST_IP_ADDRESS_IP),
    .DST_MAC_ADDRESS_IP(DST_MAC_ADDRESS_IP),
    .DST_UDP_PORT_IP   (DST_UDP_PORT_IP),
    .FRAME_VALID       (FRAME_VALID),
    .FRAME_ACK         (FRAME_ACK)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          failures = 0;
  score_t      sc [N];
  vec_t        vt [N];
  logic [31:0] exp_ip;
  logic [47:0] exp_mac;
  logic [15:0] exp_port;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Integer value of an 18-bit two's complement score, re-expressed as a 32-bit word.
  function automatic logic [31:0] ext(input score_t s);
    int v;
    v = int'(s);
    if (v >= (1 << (SW - 1))) v = v - (1 << SW);
    return 32'(v);
  endfunction

  function automatic logic [FBITS-1:0] model_frame(input score_t s [N]);
    logic [FBITS-1:0] f;
    logic [31:0]      w;
    int               best;
    f = '0;
    best = 0;
    for (int k = 0; k < N; k++) begin
      w = ext(s[k]);
      for (int b = 0; b < 4; b++) f[FBITS-1-8*(4*k+b) -: 8] = 8'((w >> (24 - 8*b)) & 32'hFF);
      if ($signed(ext(s[k])) > $signed(ext(s[best]))) best = k;
    end
`ifdef BUFF_NN_ARGMAX_EN
    f[7:0] = 8'(best);
`endif
    return f;
  endfunction

  function automatic logic [31:0] word_at(input logic [FBITS-1:0] f, input int k);
    return f[FBITS-1-32*k -: 32];
  endfunction

  // Presents sc[from..to-1] with the given R_VALID duty (%), optionally toggling FRAME_ACK.
  task automatic push(input int from, input int to, input int duty, input bit spur);
    int k;
    int guard;
    bit v;
    bit rdy;
    bit early;
    k = from;
    guard = 0;
    early = 1'b0;
    exp_ip = src_ip;
    exp_mac = src_mac;
    exp_port = src_port;
    while (k < to && guard < 1000) begin
      @(negedge ACLK);
      if (FRAME_VALID) early = 1'b1;
      v = ($urandom_range(99) < duty);
      rdy = R_READY;
      R_VALID = v;
      R_DATA = sc[k];
      FRAME_ACK = spur ? 1'($urandom_range(1)) : 1'b0;
      @(posedge ACLK);
      if (v && rdy) k++;
      guard++;
    end
    @(negedge ACLK);
    R_VALID = 1'b0;
    FRAME_ACK = 1'b0;
    chk("push_done", 32'(k), 32'(to));
    chk("valid_early", early, 1'b0);
  endtask

  task automatic check_frame(input string name);
    chk({name, "_valid"}, FRAME_VALID, 1'b1);
    chk({name, "_ready"}, R_READY, 1'b0);
    chk({name, "_frame"}, DATA_FRAME_IP, model_frame(sc));
    chk({name, "_ip"}, DST_IP_ADDRESS_IP, exp_ip);
    chk({name, "_mac"}, DST_MAC_ADDRESS_IP, exp_mac);
    chk({name, "_port"}, DST_UDP_PORT_IP, exp_port);
  endtask

  task automatic do_ack();
    @(negedge ACLK);
    FRAME_ACK = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    FRAME_ACK = 1'b0;
    chk("ack_valid_low", FRAME_VALID, 1'b0);
    chk("ack_ready_high", R_READY, 1'b1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, FRAME_VALID, 1'b0);
    chk({name, "_ready"}, R_READY, 1'b0);
    chk({name, "_frame"}, DATA_FRAME_IP, '0);
    chk({name, "_dst"}, {DST_IP_ADDRESS_IP, DST_MAC_ADDRESS_IP, DST_UDP_PORT_IP}, '0);
  endtask

  initial begin
    // Sign-extension vectors, presented as one frame in class order.
    vt[0] = '{18'h1FFFF, 32'h0001FFFF};
    vt[1] = '{18'h20000, 32'hFFFE0000};
    vt[2] = '{18'h3FFFF, 32'hFFFFFFFF};
    vt[3] = '{18'h00000, 32'h00000000};
    vt[4] = '{18'h3FE3E, 32'hFFFFFE3E};
    vt[5] = '{18'h001C2, 32'h000001C2};
    vt[6] = '{18'h00001, 32'h00000001};
    vt[7] = '{18'h20001, 32'hFFFE0001};
    vt[8] = '{18'h10000, 32'h00010000};
    vt[9] = '{18'h2FFFF, 32'hFFFEFFFF};

    ARESET = 1'b0;
    R_VALID = 1'b0;
    R_DATA = '0;
    FRAME_ACK = 1'b0;
    src_ip = '0;
    src_mac = '0;
    src_port = '0;
    repeat (3) @(negedge ACLK);
    check_zero("reset_init");
    ARESET = 1'b1;

    // Reset mid-fill after three beats discards the partial frame.
    src_ip = 32'hC0A80001;
    src_mac = 48'h112233445566;
    src_port = 16'd1234;
    for (int k = 0; k < N; k++) sc[k] = score_t'($urandom);
    begin
      int k2;
      k2 = 0;
      while (k2 < 3) begin
        @(negedge ACLK);
        R_VALID = 1'b1;
        R_DATA = sc[k2];
        if (R_READY) k2++;
      end
      @(negedge ACLK);
      R_VALID = 1'b0;
    end
    ARESET = 1'b0;
    #1;
    check_zero("reset_mid");
    @(negedge ACLK);
    ARESET = 1'b1;
    for (int k = 0; k < N; k++) sc[k] = score_t'($urandom);
    push(0, N, 100, 1'b0);
    check_frame("post_reset");
    do_ack();

    // Basic frame with known bytes.
    src_ip = 32'h01020304;
    src_mac = 48'hDEADBEEFB00B;
    src_port = 16'd666;
    for (int k = 0; k < N; k++) sc[k] = score_t'(k * 100 - 450);
    push(0, N, 100, 1'b0);
    check_frame("basic");
    chk("basic_bytes0_3", word_at(DATA_FRAME_IP, 0), 32'hFFFFFE3E);
    chk("basic_bytes36_39", word_at(DATA_FRAME_IP, 9), 32'h000001C2);

    // Backpressure: frame and destination hold while the NN keeps offering and SRC changes.
    R_VALID = 1'b1;
    R_DATA = 18'h00123;
    for (int c = 0; c < 20; c++) begin
      src_ip = $urandom;
      src_port = 16'($urandom);
      @(negedge ACLK);
      chk("bp_ready", R_READY, 1'b0);
      chk("bp_valid", FRAME_VALID, 1'b1);
      chk("bp_frame", DATA_FRAME_IP, model_frame(sc));
      chk("bp_dst", {DST_IP_ADDRESS_IP, DST_UDP_PORT_IP}, {exp_ip, exp_port});
    end
    do_ack();
    @(negedge ACLK);
    R_VALID = 1'b0;
    chk("bp_class0", word_at(DATA_FRAME_IP, 0), 32'h00000123);
    chk("bp_not_cleared", word_at(DATA_FRAME_IP, 1), 32'hFFFFFEA2);
    chk("bp_ready_after", R_READY, 1'b1);
    sc[0] = 18'h00123;
    for (int k = 1; k < N; k++) sc[k] = score_t'($urandom);
    push(1, N, 100, 1'b0);
    check_frame("bp_refill");
    do_ack();

    // Gapped input with spurious acks during fill reproduces the basic frame.
    src_ip = 32'h01020304;
    src_mac = 48'hDEADBEEFB00B;
    src_port = 16'd666;
    for (int k = 0; k < N; k++) sc[k] = score_t'(k * 100 - 450);
    push(0, N, 30, 1'b1);
    check_frame("gapped");
    chk("gapped_bytes0_3", word_at(DATA_FRAME_IP, 0), 32'hFFFFFE3E);
    do_ack();

    // Table of sign-extension vectors.
    for (int k = 0; k < N; k++) sc[k] = vt[k].score;
    push(0, N, 100, 1'b0);
    for (int k = 0; k < N; k++) chk($sformatf("sext_%0d", k), word_at(DATA_FRAME_IP, k), vt[k].word);
    do_ack();

`ifdef BUFF_NN_ARGMAX_EN
    // Argmax: tie at 500 keeps class 3; all-negative picks the least negative.
    for (int k = 0; k < N; k++) sc[k] = score_t'(k * 10);
    sc[3] = score_t'(500);
    sc[7] = score_t'(500);
    push(0, N, 100, 1'b0);
    chk("argmax_tie", DATA_FRAME_IP[7:0], 8'd3);
    do_ack();
    for (int k = 0; k < N; k++) sc[k] = score_t'(-1000 + k * 7);
    sc[9] = score_t'(-5000);
    sc[2] = score_t'(-3);
    push(0, N, 100, 1'b0);
    chk("argmax_neg", DATA_FRAME_IP[7:0], 8'd2);
    do_ack();
`endif

    // Random frames against the model.
    for (int f = 0; f < 8; f++) begin
      src_ip = $urandom;
      src_mac = {16'($urandom), $urandom};
      src_port = 16'($urandom);
      for (int k = 0; k < N; k++) sc[k] = score_t'($urandom);
      push(0, N, 20 + int'($urandom_range(80)), 1'b1);
      check_frame($sformatf("rand%0d", f));
      repeat ($urandom_range(4)) @(negedge ACLK);
      chk("rand_hold", DATA_FRAME_IP, model_frame(sc));
      do_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
